wb4_to_pi1: RTL and testbench

WB4_TO_PI1 -- requirements
Module: wb4_to_pi1

---
 rtl/wb4_to_pi1.sv | 137 +++++++++++++
 tb/tb_wb4_to_pi1.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb4_to_pi1.sv
// Wishbone B4 pipelined slave to pi1 master bridge, one pi1 op in flight at a time.
// Define WB4_TO_PI1_SKID_EN to add a second request entry (skid buffer) that hides the stall.
module wb4_to_pi1 #(
  parameter int ARCHBITSZ = 32
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     wb4_cyc_i,
  input  logic                                     wb4_stb_i,
  input  logic                                     wb4_we_i,
  input  logic [ARCHBITSZ-1:0]                     wb4_addr_i,
  input  logic [ARCHBITSZ-1:0]                     wb4_data_i,
  input  logic [ARCHBITSZ/8-1:0]                   wb4_sel_i,
  output logic                                     wb4_stall_o,
  output logic                                     wb4_ack_o,
  output logic [ARCHBITSZ-1:0]                     wb4_data_o,
  output logic [1:0]                               pi1_op_o,
  output logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0] pi1_addr_o,
  output logic [ARCHBITSZ-1:0]                     pi1_data_o,
  output logic [ARCHBITSZ/8-1:0]                   pi1_sel_o,
  input  logic [ARCHBITSZ-1:0]                     pi1_data_i,
  input  logic                                     pi1_rdy_i
);

  localparam int SELW = ARCHBITSZ / 8;
  localparam int LSB  = $clog2(SELW);
  localparam int PAW  = ARCHBITSZ - LSB;

  localparam logic [1:0] OP_NOOP = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;

  typedef enum logic [1:0] {IDLE, CMD, RESP, ACK} state_t;

  typedef struct packed {
    logic                 we;
    logic [PAW-1:0]       addr;
    logic [ARCHBITSZ-1:0] data;
    logic [SELW-1:0]      sel;
  } req_t;

  state_t               state_reg, state_next;
  req_t                 req_reg, req_in, load_req;
  logic [ARCHBITSZ-1:0] rdata_reg;
  logic                 drop_reg;
  logic                 accept, load_main, capture, buf_pending;
  logic                 unused_addr_bits;

  assign req_in = '{we: wb4_we_i, addr: wb4_addr_i[ARCHBITSZ-1:LSB],
                    data: wb4_data_i, sel: wb4_sel_i};
  assign unused_addr_bits = ^wb4_addr_i[LSB-1:0];

`ifdef WB4_TO_PI1_SKID_EN
  // Second entry catches a request that arrives while the first one is still on pi1.
  req_t skid_reg;
  logic skid_valid_reg, skid_push;

  assign skid_push   = accept && (state_reg == CMD || state_reg == RESP);
  assign buf_pending = skid_valid_reg;
  assign load_req    = skid_valid_reg ? skid_reg : req_in;
  assign wb4_stall_o = skid_valid_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skid_reg       <= '0;
      skid_valid_reg <= 1'b0;
    end else if (skid_push) begin
      skid_reg       <= req_in;
      skid_valid_reg <= 1'b1;
    end else if (load_main || !wb4_cyc_i) begin
      skid_valid_reg <= 1'b0;
    end
  end
`else
  assign buf_pending = 1'b0;
  assign load_req    = req_in;
  assign wb4_stall_o = (state_reg != IDLE);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = wb4_cyc_i && wb4_stb_i && !wb4_stall_o;
    load_main  = 1'b0;
    capture    = 1'b0;
    pi1_op_o   = OP_NOOP;
    wb4_ack_o  = 1'b0;
    case (state_reg)
      IDLE: load_main = accept;
      CMD: begin
        pi1_op_o = req_reg.we ? OP_WR : OP_RD;
        if (pi1_rdy_i) state_next = RESP;
      end
      RESP: begin
        if (pi1_rdy_i) begin
          capture    = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        wb4_ack_o  = wb4_cyc_i && !drop_reg;
        state_next = IDLE;
        load_main  = (buf_pending && wb4_cyc_i) || accept;
      end
      default: state_next = IDLE;
    endcase
    // An all-zero byte select never reaches pi1 and is acknowledged straight away.
    if (load_main) state_next = (load_req.sel == '0) ? ACK : CMD;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_reg   <= '0;
      rdata_reg <= '0;
      drop_reg  <= 1'b0;
    end else begin
      if (load_main) begin
        req_reg   <= load_req;
        rdata_reg <= '0;
        drop_reg  <= 1'b0;
      end else if (state_reg != IDLE && !wb4_cyc_i) begin
        drop_reg  <= 1'b1;
      end
      if (capture) rdata_reg <= req_reg.we ? '0 : pi1_data_i;
    end
  end

  assign pi1_addr_o = req_reg.addr;
  assign pi1_data_o = req_reg.data;
  assign pi1_sel_o  = req_reg.sel;
  assign wb4_data_o = rdata_reg;

endmodule

// File: tb/tb_wb4_to_pi1.sv
// Bench for wb4_to_pi1: table of single transfers plus cycle-drop, reset and back-to-back sequences.
// Acks are matched in order against a queue of expected read data filled at acceptance.
`timescale 1ns/1ps
module tb_wb4_to_pi1;
  localparam int AW  = 32;
  localparam int SW  = AW / 8;
  localparam int PAW = AW - 2;
  localparam logic [1:0] NOOP = 2'b00;
  localparam logic [1:0] WR   = 2'b01;
  localparam logic [1:0] RD   = 2'b10;

  logic           clk = 1'b0;
  logic           rst;
  logic           cyc, stb, we, rdy, use_model;
  logic [AW-1:0]  addr, wdata, rdata, pdata, pi1_rdata, rdat_drv;
  logic [SW-1:0]  sel, psel;
  logic           stall, ack;
  logic [1:0]     op;
  logic [PAW-1:0] paddr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW-1:0] sb_q[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [31:0] rdat;
    int          rdy_low;
    logic [1:0]  exp_op;
    logic [29:0] exp_paddr;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  // pi1 target model for the back-to-back run: data is a fixed function of the word address.
  function automatic logic [31:0] model_data(input logic [PAW-1:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign pi1_rdata = use_model ? model_data(paddr) : rdat_drv;

  wb4_to_pi1 #(.ARCHBITSZ(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .wb4_cyc_i(cyc), .wb4_stb_i(stb), .wb4_we_i(we),
    .wb4_addr_i(addr), .wb4_data_i(wdata), .wb4_sel_i(sel),
    .wb4_stall_o(stall), .wb4_ack_o(ack), .wb4_data_o(rdata),
    .pi1_op_o(op), .pi1_addr_o(paddr), .pi1_data_o(pdata), .pi1_sel_o(psel),
    .pi1_data_i(pi1_rdata), .pi1_rdy_i(rdy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && ack === 1'b1) begin
      check("ack_needs_cyc", cyc, 1'b1);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack=1 data=0x%0h, required ack=0", rdata);
      end else begin
        check("ack_data", rdata, sb_q.pop_front());
      end
    end
  end

  task automatic wait_stall_free();
    int guard = 0;
    while (stall !== 1'b0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("stall_free", stall, 1'b0);
  endtask

  task automatic do_req(input vec_t v, input int tag);
    int lat, n_ack, n_op;
    bit op_ok;
    wait_stall_free();
    cyc = 1'b1; stb = 1'b1; we = v.we; addr = v.addr; wdata = v.data; sel = v.sel;
    rdat_drv = v.rdat;
    rdy = (v.rdy_low == 0);
    @(posedge clk); #1;
    stb = 1'b0;
    sb_q.push_back(v.exp_rdata);
    lat = -1; n_ack = 0; n_op = 0; op_ok = 1'b1;
    for (int k = 1; k <= v.exp_lat + 3; k++) begin
      rdy = (k > v.rdy_low);
      if (op !== NOOP) begin
        n_op++;
        if (op !== v.exp_op || paddr !== v.exp_paddr || pdata !== v.data || psel !== v.sel)
          op_ok = 1'b0;
      end
      if (ack === 1'b1) begin
        n_ack++;
        if (lat < 0) lat = k;
      end
      @(posedge clk); #1;
    end
    check("op_cycles", n_op, (v.sel == 4'h0) ? 0 : v.rdy_low + 1);
    check("op_fields", op_ok, 1'b1);
    check("ack_latency", lat, v.exp_lat);
    check("ack_count", n_ack, 1);
    cyc = 1'b0;
    $display("txn %0d: we=%0b addr=0x%08h sel=0x%0h ack_latency=%0d pi1_op_cycles=%0d",
             tag, v.we, v.addr, v.sel, lat, n_op);
  endtask

  logic [31:0] b2b_addr[3];
  int          acc_edge[3];
  int          exp_edge[3];
  int          idx, n_op, guard;
  bit          acc;
  vec_t        extra;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 32'h0000_1004, 32'h0,         4'hF, 32'hDEAD_BEEF, 0, RD,   30'h401,       32'hDEAD_BEEF, 3};
    vecs[1] = '{1'b1, 32'h0000_0008, 32'h1234_5678, 4'h3, 32'h5555_5555, 4, WR,   30'h2,         32'h0,         7};
    vecs[2] = '{1'b1, 32'h0000_0020, 32'h0000_AAAA, 4'h0, 32'h1111_1111, 0, NOOP, 30'h8,         32'h0,         1};
    vecs[3] = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 32'h2222_2222, 0, NOOP, 30'h9,         32'h0,         1};
    vecs[4] = '{1'b0, 32'h0000_FFFC, 32'h0,         4'h8, 32'h0BAD_F00D, 2, RD,   30'h3FFF,      32'h0BAD_F00D, 5};
    vecs[5] = '{1'b1, 32'h0000_0007, 32'hCAFE_F00D, 4'hC, 32'h3333_3333, 0, WR,   30'h1,         32'h0,         3};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'h0,         4'h1, 32'h1357_9BDF, 1, RD,   30'h3FFF_FFFF, 32'h1357_9BDF, 4};

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
    rdy = 1'b0; rdat_drv = '0; use_model = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_op", op, NOOP);
    check("reset_ack_stall", {ack, stall}, 2'b00);
    check("reset_outs", {psel, paddr, rdata}, 0);
    check("reset_pdata", pdata, 0);
    rst = 1'b0;

    foreach (vecs[i]) do_req(vecs[i], i);

    // Asynchronous reset clears the held read data and the pi1 address/select.
    #2 rst = 1'b1;
    #1;
    check("async_rst_rdata", rdata, 0);
    check("async_rst_pi1", {psel, paddr}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // cyc dropped while the write sits in CMD: op held until rdy, no ack.
    wait_stall_free();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'hA5A5_0F0F; sel = 4'hF; rdy = 1'b0;
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0;
    n_op = 0;
    for (int k = 0; k < 3; k++) begin
      if (op === WR) n_op++;
      @(posedge clk); #1;
    end
    check("drop_cmd_hold", n_op, 3);
    check("drop_cmd_op", op, WR);
    rdy = 1'b1;
    @(posedge clk); #1;
    check("drop_cmd_resp_op", op, NOOP);
    @(posedge clk); #1;
    cyc = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc = 1'b0;
    $display("txn drop_cmd: write 0x40 completed on pi1 with wb4_cyc_i low");

    // cyc dropped during RESP: response still consumed, no ack, next read is normal.
    wait_stall_free();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h200; wdata = '0; sel = 4'hF; rdy = 1'b1;
    rdat_drv = 32'h7777_7777;
    @(posedge clk); #1;
    stb = 1'b0;
    check("drop_resp_cmd_op", op, RD);
    @(posedge clk); #1;
    cyc = 1'b0; rdy = 1'b0;
    n_op = 0;
    for (int k = 0; k < 2; k++) begin
      if (op !== NOOP) n_op++;
      @(posedge clk); #1;
    end
    check("drop_resp_noop", n_op, 0);
    rdy = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b1;
    @(posedge clk); #1;
    check("drop_resp_idle", stall, 1'b0);
    cyc = 1'b0;
    $display("txn drop_resp: read 0x200 completed on pi1 with ack suppressed");
    extra = '{1'b0, 32'h0000_2000, 32'h0, 4'hF, 32'h600D_CAFE, 0, RD, 30'h800, 32'h600D_CAFE, 3};
    do_req(extra, 100);

    // Reset while in CMD: op drops in the same cycle, no ack, new request taken right after.
    wait_stall_free();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h300; wdata = 32'h8765_4321; sel = 4'hF; rdy = 1'b0;
    @(posedge clk); #1;
    stb = 1'b0;
    check("rst_pre_op", op, WR);
    #2 rst = 1'b1;
    #1;
    check("rst_cmd_op", op, NOOP);
    check("rst_cmd_outs", {ack, stall, psel, paddr}, 0);
    check("rst_cmd_pdata", pdata, 0);
    rdy = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("txn rst_cmd: write 0x300 aborted by reset");
    extra = '{1'b0, 32'h0000_3000, 32'h0, 4'h5, 32'h0F1E_2D3C, 0, RD, 30'hC00, 32'h0F1E_2D3C, 3};
    do_req(extra, 101);

    // Three back-to-back reads with stb held high; acceptance edges show the stall pattern.
    b2b_addr[0] = 32'h100; b2b_addr[1] = 32'h104; b2b_addr[2] = 32'h108;
`ifdef WB4_TO_PI1_SKID_EN
    exp_edge[0] = 0; exp_edge[1] = 1; exp_edge[2] = 4;
`else
    exp_edge[0] = 0; exp_edge[1] = 4; exp_edge[2] = 8;
`endif
    acc_edge[0] = -1; acc_edge[1] = -1; acc_edge[2] = -1;
    wait_stall_free();
    use_model = 1'b1; rdy = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; wdata = '0; sel = 4'hF; addr = b2b_addr[0];
    idx = 0;
    for (int c = 0; c < 40 && idx < 3; c++) begin
      acc = (stall === 1'b0);
      @(posedge clk); #1;
      if (acc) begin
        sb_q.push_back(model_data(b2b_addr[idx][31:2]));
        acc_edge[idx] = c;
        idx++;
        if (idx < 3) addr = b2b_addr[idx];
        else         stb = 1'b0;
      end
    end
    guard = 0;
    while (sb_q.size() > 0 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    check("b2b_accepts", idx, 3);
    for (int i = 0; i < 3; i++) check("b2b_accept_edge", acc_edge[i], exp_edge[i]);
    check("b2b_drain", sb_q.size(), 0);
    $display("txn b2b: reads accepted at edges %0d %0d %0d", acc_edge[0], acc_edge[1], acc_edge[2]);
    cyc = 1'b0; use_model = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check("final_queue_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
